// File: rtl/gpr_pkg.sv
// Shared defaults and instruction-kind encodings for the GPR file and its decode neighbours.
// The kind/fn2 codes are consumed by decode, which derives we and ld_issue outside this block.
package gpr_pkg;

    localparam int GPR_DATA_W   = 8;
    localparam int GPR_NREG     = 8;
    localparam int GPR_MAX_PEND = 2;

    localparam logic [3:0] KIND_REG_REG = 4'b0000;
    localparam logic [3:0] KIND_REG_IMM = 4'b0001;
    localparam logic [3:0] KIND_SHIFT   = 4'b0010;
    localparam logic [3:0] KIND_MEM_IO  = 4'b0011;
    localparam logic [1:0] FN2_LOAD     = 2'b00;

endpackage

// File: rtl/gpr_scoreboard.sv
// Load scoreboard: per-register busy bits, outstanding-load counter, issue/return handshake.
// ld_ready is the load-return handshake: a return is accepted in any cycle where ld_valid && ld_ready.
module gpr_scoreboard
    import gpr_pkg::*;
#(
    parameter int NREG     = GPR_NREG,
    parameter int ADDR_W   = $clog2(NREG),
    parameter int MAX_PEND = GPR_MAX_PEND
) (
    input  logic              ck,
    input  logic              res,
    input  logic              ck2,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic              ld_issue,
    input  logic [ADDR_W-1:0] ld_daddr,
    input  logic              ld_valid,
    input  logic [ADDR_W-1:0] ld_waddr,
    output logic [NREG-1:0]   busy,
    output logic              issue_ok,
    output logic              ld_ready,
    output logic              ld_accept
);

    localparam int PEND_W = $clog2(MAX_PEND + 1);

    logic [NREG-1:0]   busy_q, busy_d;
    logic [PEND_W-1:0] pend_q, pend_d;
    logic              g;
    logic              issue_take;

    // res is folded into the gate so ld_ready reads 0 while reset is held.
    assign g          = res && !ck2;
    assign issue_ok   = (pend_q < PEND_W'(MAX_PEND));
    assign ld_ready   = g && !(we && (waddr == ld_waddr) && (waddr != '0));
    assign ld_accept  = ld_valid && ld_ready;
    assign issue_take = g && ld_issue && issue_ok && (ld_daddr != '0);
    assign busy       = busy_q;

    always_comb begin
        busy_d = busy_q;
        pend_d = pend_q;
        // Clear before set so a same-register issue overrides the return.
        if (ld_accept) begin
            busy_d[ld_waddr] = 1'b0;
        end
        if (issue_take) begin
            busy_d[ld_daddr] = 1'b1;
        end
        busy_d[0] = 1'b0;
        if (issue_take && !ld_accept) begin
            pend_d = pend_q + PEND_W'(1);
        end else if (ld_accept && !issue_take && (pend_q != '0)) begin
            pend_d = pend_q - PEND_W'(1);
        end
    end

    always_ff @(posedge ck or negedge res) begin
        if (!res) begin
            busy_q <= '0;
            pend_q <= '0;
        end else begin
            busy_q <= busy_d;
            pend_q <= pend_d;
        end
    end

endmodule

// File: rtl/gpr_file_sb.sv
// General-purpose register file with ALU and load-return write ports, three read ports with
// optional same-cycle forwarding, and an integrated load scoreboard.
module gpr_file_sb
    import gpr_pkg::*;
#(
    parameter int DATA_W   = GPR_DATA_W,
    parameter int NREG     = GPR_NREG,
    parameter int ADDR_W   = $clog2(NREG),
    parameter int MAX_PEND = GPR_MAX_PEND,
    parameter int BYPASS   = 1
) (
    input  logic              ck,
    input  logic              res,
    input  logic              ck2,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    input  logic [ADDR_W-1:0] saddr,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    output logic [DATA_W-1:0] store_d,
    output logic              busy1,
    output logic              busy2,
    output logic              busy_s,
    input  logic              ld_issue,
    input  logic [ADDR_W-1:0] ld_daddr,
    output logic              issue_ok,
    input  logic              ld_valid,
    input  logic [ADDR_W-1:0] ld_waddr,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ready
);

    logic [DATA_W-1:0] gpr_q [NREG];
    logic [DATA_W-1:0] gpr_d [NREG];
    logic [NREG-1:0]   busy;
    logic              ld_accept;
    logic              alu_wr;
    logic              ld_wr;

    logic [ADDR_W-1:0] ra [3];
    logic [DATA_W-1:0] rv [3];
    logic              rb [3];

    gpr_scoreboard #(
        .NREG     (NREG),
        .ADDR_W   (ADDR_W),
        .MAX_PEND (MAX_PEND)
    ) u_sb (
        .ck        (ck),
        .res       (res),
        .ck2       (ck2),
        .we        (we),
        .waddr     (waddr),
        .ld_issue  (ld_issue),
        .ld_daddr  (ld_daddr),
        .ld_valid  (ld_valid),
        .ld_waddr  (ld_waddr),
        .busy      (busy),
        .issue_ok  (issue_ok),
        .ld_ready  (ld_ready),
        .ld_accept (ld_accept)
    );

    assign alu_wr = res && !ck2 && we && (waddr != '0);
    assign ld_wr  = ld_accept && (ld_waddr != '0);

    // ld_ready already blocks a load return colliding with the ALU write, so the two never alias.
    always_comb begin
        gpr_d = gpr_q;
        if (alu_wr) begin
            gpr_d[waddr] = wdata;
        end
        if (ld_wr) begin
            gpr_d[ld_waddr] = ld_data;
        end
    end

    always_ff @(posedge ck or negedge res) begin
        if (!res) begin
            for (int i = 0; i < NREG; i++) begin
                gpr_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREG; i++) begin
                gpr_q[i] <= gpr_d[i];
            end
        end
    end

    assign ra[0] = raddr1;
    assign ra[1] = raddr2;
    assign ra[2] = saddr;

    // Forwarding priority: accepted load data, then ALU write data, then the stored value.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            rv[i] = gpr_q[ra[i]];
            rb[i] = busy[ra[i]];
            if (ra[i] == '0) begin
                rv[i] = '0;
                rb[i] = 1'b0;
            end else if ((BYPASS != 0) && ld_wr && (ld_waddr == ra[i])) begin
                rv[i] = ld_data;
                rb[i] = 1'b0;
            end else if ((BYPASS != 0) && alu_wr && (waddr == ra[i])) begin
                rv[i] = wdata;
            end
        end
    end

    assign rd1     = rv[0];
    assign rd2     = rv[1];
    assign store_d = rv[2];
    assign busy1   = rb[0];
    assign busy2   = rb[1];
    assign busy_s  = rb[2];

endmodule

// File: tb/tb_gpr_file_sb.sv
// Directed vector bench for gpr_file_sb: a per-cycle stimulus/expectation table plus a
// hand-written asynchronous reset sequence with loads outstanding.
module tb_gpr_file_sb;

    logic       ck = 1'b0;
    logic       res = 1'b0;
    logic       ck2 = 1'b0;
    logic       we = 1'b0;
    logic [2:0] waddr = '0;
    logic [7:0] wdata = '0;
    logic [2:0] raddr1 = '0;
    logic [2:0] raddr2 = '0;
    logic [2:0] saddr = '0;
    logic [7:0] rd1, rd2, store_d;
    logic       busy1, busy2, busy_s;
    logic       ld_issue = 1'b0;
    logic [2:0] ld_daddr = '0;
    logic       issue_ok;
    logic       ld_valid = 1'b0;
    logic [2:0] ld_waddr = '0;
    logic [7:0] ld_data = '0;
    logic       ld_ready;

    int n_tests = 0;
    int n_fail  = 0;

    gpr_file_sb dut (
        .ck       (ck),
        .res      (res),
        .ck2      (ck2),
        .we       (we),
        .waddr    (waddr),
        .wdata    (wdata),
        .raddr1   (raddr1),
        .raddr2   (raddr2),
        .saddr    (saddr),
        .rd1      (rd1),
        .rd2      (rd2),
        .store_d  (store_d),
        .busy1    (busy1),
        .busy2    (busy2),
        .busy_s   (busy_s),
        .ld_issue (ld_issue),
        .ld_daddr (ld_daddr),
        .issue_ok (issue_ok),
        .ld_valid (ld_valid),
        .ld_waddr (ld_waddr),
        .ld_data  (ld_data),
        .ld_ready (ld_ready)
    );

    // clock / reset
    always #5 ck = ~ck;

    typedef struct {
        logic       ck2;
        logic       we;
        logic [2:0] waddr;
        logic [7:0] wdata;
        logic       iss;
        logic [2:0] daddr;
        logic       vld;
        logic [2:0] lwaddr;
        logic [7:0] ldata;
        logic [2:0] r1;
        logic [2:0] r2;
        logic [2:0] s;
        logic [7:0] e_rd1;
        logic [7:0] e_rd2;
        logic [7:0] e_sd;
        logic       e_b1;
        logic       e_b2;
        logic       e_bs;
        logic       e_ok;
        logic       e_rdy;
    } vec_t;

    vec_t tv [$];

    task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (step %0d): got %02h expected %02h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        ck2      = v.ck2;
        we       = v.we;
        waddr    = v.waddr;
        wdata    = v.wdata;
        ld_issue = v.iss;
        ld_daddr = v.daddr;
        ld_valid = v.vld;
        ld_waddr = v.lwaddr;
        ld_data  = v.ldata;
        raddr1   = v.r1;
        raddr2   = v.r2;
        saddr    = v.s;
    endtask

    task automatic check_vec(input vec_t v, input int idx);
        chk("rd1", idx, rd1, v.e_rd1);
        chk("rd2", idx, rd2, v.e_rd2);
        chk("store_d", idx, store_d, v.e_sd);
        chk("busy1", idx, {7'd0, busy1}, {7'd0, v.e_b1});
        chk("busy2", idx, {7'd0, busy2}, {7'd0, v.e_b2});
        chk("busy_s", idx, {7'd0, busy_s}, {7'd0, v.e_bs});
        chk("issue_ok", idx, {7'd0, issue_ok}, {7'd0, v.e_ok});
        chk("ld_ready", idx, {7'd0, ld_ready}, {7'd0, v.e_rdy});
    endtask

    function automatic vec_t idle_vec();
        vec_t v;
        v = '{1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b0, 3'd0, 8'h00, 3'd0, 3'd0, 3'd0,
              8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        return v;
    endfunction

    initial begin
        //       ck2 we wa   wdata  iss da   vld lwa  ldata  r1   r2   s    rd1    rd2    sd     b1 b2 bs ok rdy
        // write/read, r0 writes dropped, ck2 gating
        tv.push_back('{0, 1'b0, 3'd0, 8'h00, 0, 3'd0, 0, 3'd0, 8'h00, 3'd3, 3'd0, 3'd0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 1, 1});
        tv.push_back('{0, 1'b1, 3'd3, 8'hA5, 0, 3'd0, 0, 3'd0, 8'h00, 3'd3, 3'd0, 3'd0, 8'hA5, 8'h00, 8'h00, 0, 0, 0, 1, 1});
        tv.push_back('{0, 1'b0, 3'd0, 8'h00, 0, 3'd0, 0, 3'd0, 8'h00, 3'd3, 3'd0, 3'd0, 8'hA5, 8'h00, 8'h00, 0, 0, 0, 1, 1});
        tv.push_back('{0, 1'b1, 3'd0, 8'hFF, 0, 3'd0, 0, 3'd0, 8'h00, 3'd0, 3'd3, 3'd0, 8'h00, 8'hA5, 8'h00, 0, 0, 0, 1, 1});
        tv.push_back('{1, 1'b1, 3'd2, 8'h11, 0, 3'd0, 0, 3'd0, 8'h00, 3'd2, 3'd0, 3'd0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 1, 0});
        tv.push_back('{0, 1'b0, 3'd0, 8'h00, 0, 3'd0, 0, 3'd0, 8'h00, 3'd2, 3'd0, 3'd0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 1, 1});
        // issue r5, then return with same-cycle forwarding
        tv.push_back('{0, 1'b0, 3'd0, 8'h00, 1, 3'd5, 0, 3'd0, 8'h00, 3'd5, 3'd0, 3'd0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 1, 1});
        tv.push_back('{0, 1'b0, 3'd0, 8'h00, 0, 3'd0, 0, 3'd0, 8'h00, 3'd5, 3'd0, 3'd0, 8'h00, 8'h00, 8'h00, 1, 0, 0, 1, 1});
        tv.push_back('{0, 1'b0, 3'd0, 8'h00, 0, 3'd0, 1, 3'd5, 8'h3C, 3'd5, 3'd5, 3'd0, 8'h3C, 8'h3C, 8'h00, 0, 0, 0, 1, 1});
        tv.push_back('{0, 1'b0, 3'd0, 8'h00, 0, 3'd0, 0, 3'd0, 8'h00, 3'd5, 3'd0, 3'd5, 8'h3C, 8'h00, 8'h3C, 0, 0, 0, 1, 1});
        // fill to MAX_PEND, dropped third issue, accept frees a slot
        tv.push_back('{0, 1'b0, 3'd0, 8'h00, 1, 3'd1, 0, 3'd0, 8'h00, 3'd1, 3'd0, 3'd0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 1, 1});
        tv.push_back('{0, 1'b0, 3'd0, 8'h00, 1, 3'd2, 0, 3'd0, 8'h00, 3'd1, 3'd2, 3'd0, 8'h00, 8'h00, 8'h00, 1, 0, 0, 1, 1});
        tv.push_back('{0, 1'b0, 3'd0, 8'h00, 1, 3'd6, 0, 3'd0, 8'h00, 3'd1, 3'd2, 3'd6, 8'h00, 8'h00, 8'h00, 1, 1, 0, 0, 1});
        tv.push_back('{0, 1'b0, 3'd0, 8'h00, 0, 3'd0, 1, 3'd1, 8'h42, 3'd1, 3'd2, 3'd6, 8'h42, 8'h00, 8'h00, 0, 1, 0, 0, 1});
        tv.push_back('{0, 1'b0, 3'd0, 8'h00, 0, 3'd0, 0, 3'd0, 8'h00, 3'd1, 3'd2, 3'd6, 8'h42, 8'h00, 8'h00, 0, 1, 0, 1, 1});
        // ALU collision stalls the return one cycle
        tv.push_back('{0, 1'b1, 3'd4, 8'h77, 0, 3'd0, 1, 3'd4, 8'h9E, 3'd4, 3'd0, 3'd0, 8'h77, 8'h00, 8'h00, 0, 0, 0, 1, 0});
        tv.push_back('{0, 1'b0, 3'd0, 8'h00, 0, 3'd0, 1, 3'd4, 8'h9E, 3'd4, 3'd0, 3'd0, 8'h9E, 8'h00, 8'h00, 0, 0, 0, 1, 1});
        tv.push_back('{0, 1'b0, 3'd0, 8'h00, 0, 3'd0, 0, 3'd0, 8'h00, 3'd4, 3'd2, 3'd0, 8'h9E, 8'h00, 8'h00, 0, 1, 0, 1, 1});
        // issue and return to the same register in one cycle: busy stays set, pend unchanged
        tv.push_back('{0, 1'b0, 3'd0, 8'h00, 1, 3'd3, 0, 3'd0, 8'h00, 3'd3, 3'd0, 3'd0, 8'hA5, 8'h00, 8'h00, 0, 0, 0, 1, 1});
        tv.push_back('{0, 1'b0, 3'd0, 8'h00, 1, 3'd3, 1, 3'd3, 8'h5A, 3'd3, 3'd0, 3'd0, 8'h5A, 8'h00, 8'h00, 0, 0, 0, 1, 1});
        tv.push_back('{0, 1'b0, 3'd0, 8'h00, 0, 3'd0, 0, 3'd0, 8'h00, 3'd3, 3'd0, 3'd0, 8'h5A, 8'h00, 8'h00, 1, 0, 0, 1, 1});
        tv.push_back('{0, 1'b0, 3'd0, 8'h00, 1, 3'd7, 0, 3'd0, 8'h00, 3'd0, 3'd7, 3'd0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 1, 1});
        tv.push_back('{0, 1'b0, 3'd0, 8'h00, 0, 3'd0, 0, 3'd0, 8'h00, 3'd3, 3'd7, 3'd0, 8'h5A, 8'h00, 8'h00, 1, 1, 0, 0, 1});
        // both write ports to different registers in one cycle
        tv.push_back('{0, 1'b1, 3'd6, 8'h66, 0, 3'd0, 1, 3'd7, 8'h77, 3'd6, 3'd7, 3'd0, 8'h66, 8'h77, 8'h00, 0, 0, 0, 0, 1});
        tv.push_back('{0, 1'b0, 3'd0, 8'h00, 0, 3'd0, 0, 3'd0, 8'h00, 3'd6, 3'd7, 3'd3, 8'h66, 8'h77, 8'h5A, 0, 0, 1, 1, 1});
        tv.push_back('{0, 1'b0, 3'd0, 8'h00, 1, 3'd1, 0, 3'd0, 8'h00, 3'd1, 3'd3, 3'd0, 8'h42, 8'h5A, 8'h00, 0, 1, 0, 1, 1});

        // reset block: hold res low across an edge, check reset outputs, release away from the edge
        res = 1'b0;
        drive(idle_vec());
        #1;
        chk("reset_rd1", -1, rd1, 8'h00);
        chk("reset_ok", -1, {7'd0, issue_ok}, 8'h01);
        chk("reset_rdy", -1, {7'd0, ld_ready}, 8'h00);
        @(posedge ck);
        #1;
        res = 1'b1;

        for (int i = 0; i < tv.size(); i++) begin
            drive(tv[i]);
            #2;
            check_vec(tv[i], i);
            @(posedge ck);
            #1;
        end

        // r1, r2, r3 busy with two loads pending; pull res low mid-cycle
        drive(idle_vec());
        raddr1 = 3'd1;
        raddr2 = 3'd3;
        saddr  = 3'd4;
        #1;
        chk("pre_busy1", 100, {7'd0, busy1}, 8'h01);
        chk("pre_busy2", 100, {7'd0, busy2}, 8'h01);
        chk("pre_ok", 100, {7'd0, issue_ok}, 8'h00);
        chk("pre_store_d", 100, store_d, 8'h9E);
        res = 1'b0;
        #1;
        chk("async_rd1", 101, rd1, 8'h00);
        chk("async_rd2", 101, rd2, 8'h00);
        chk("async_store_d", 101, store_d, 8'h00);
        chk("async_busy1", 101, {7'd0, busy1}, 8'h00);
        chk("async_busy2", 101, {7'd0, busy2}, 8'h00);
        chk("async_ok", 101, {7'd0, issue_ok}, 8'h01);
        chk("async_rdy", 101, {7'd0, ld_ready}, 8'h00);
        @(posedge ck);
        #1;
        res = 1'b1;
        @(posedge ck);
        #1;
        chk("post_rd2", 102, rd2, 8'h00);
        chk("post_busy2", 102, {7'd0, busy2}, 8'h00);
        chk("post_ok", 102, {7'd0, issue_ok}, 8'h01);
        chk("post_rdy", 102, {7'd0, ld_ready}, 8'h01);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
